// File: rtl/encoder_pkg.sv
// Shared types and width helpers for the sequential priority encoder.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest r with 2^r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned in_bits_of(input int unsigned out_bits);
    return 32'(1) << out_bits;
  endfunction

  function automatic int unsigned num_segs_of(input int unsigned out_bits,
                                              input int unsigned seg_bits);
    return in_bits_of(out_bits) / seg_bits;
  endfunction

  // Derived constants for the default configuration.
  localparam int unsigned DEFAULT_OUT_BITS = 8;
  localparam int unsigned DEFAULT_SEG_BITS = 32;
  localparam int unsigned IN_BITS  = in_bits_of(DEFAULT_OUT_BITS);
  localparam int unsigned NUM_SEGS = num_segs_of(DEFAULT_OUT_BITS, DEFAULT_SEG_BITS);

endpackage

// File: rtl/seg_priority_encoder.sv
// Combinational lowest-set-bit encoder for one scan segment.
module seg_priority_encoder #(
  parameter int unsigned SEG_BITS = 32,
  parameter int unsigned IDX_BITS = 5
) (
  input  logic [SEG_BITS-1:0] seg,
  output logic [IDX_BITS-1:0] idx,
  output logic                any
);

  // Walk from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = int'(SEG_BITS) - 1; i >= 0; i--) begin
      if (seg[i]) idx = IDX_BITS'(i);
    end
  end

  assign any = |seg;

endmodule

// File: rtl/priority_encoder_seq.sv
// Multi-cycle lowest-set-bit encoder scanning SEG_BITS bits per cycle.
// Optional multi-hot detection: define PRIORITY_ENCODER_SEQ_ONEHOT_CHECK_EN.
module priority_encoder_seq
  import encoder_pkg::*;
#(
  parameter int unsigned OUT_BITS = 8,
  parameter int unsigned SEG_BITS = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [in_bits_of(OUT_BITS)-1:0]   input_bits,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_BITS-1:0]               output_bits,
  output logic                              out_zero,
  output logic                              out_multi
);

  localparam int unsigned IN_BITS  = in_bits_of(OUT_BITS);
  localparam int unsigned NUM_SEGS = IN_BITS / SEG_BITS;
  localparam int unsigned SIW      = idx_bits(NUM_SEGS);
  localparam int unsigned LW       = idx_bits(SEG_BITS);

  state_e state_q, state_d;

  logic [NUM_SEGS-1:0][SEG_BITS-1:0] vec_q;
  logic [SIW-1:0]      seg_idx_q;
  logic [SEG_BITS-1:0] seg_c;
  logic [LW-1:0]       local_idx;
  logic                seg_any;
  logic                last_seg;
  logic [OUT_BITS-1:0] hit_idx;

  logic in_ready_d, out_valid_d;
  logic load_vec, advance, finish_hit, finish_zero;

  // Segment mux over the latched vector feeds the single encoder instance.
  assign seg_c    = vec_q[seg_idx_q];
  assign last_seg = (seg_idx_q == SIW'(NUM_SEGS - 1));

  seg_priority_encoder #(
    .SEG_BITS (SEG_BITS),
    .IDX_BITS (LW)
  ) u_seg_enc (
    .seg (seg_c),
    .idx (local_idx),
    .any (seg_any)
  );

  // Index is the segment number concatenated with the in-segment offset.
  generate
    if (NUM_SEGS == 1) begin : g_one_seg
      assign hit_idx = OUT_BITS'(local_idx);
    end else if (SEG_BITS == 1) begin : g_bit_seg
      assign hit_idx = OUT_BITS'(seg_idx_q);
    end else begin : g_concat
      assign hit_idx = {seg_idx_q, local_idx};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic with early exit on the first nonzero segment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SCAN;
      SCAN:    if (seg_any || last_seg) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode; handshake outputs are registered from the next state.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    load_vec    = 1'b0;
    advance     = 1'b0;
    finish_hit  = 1'b0;
    finish_zero = 1'b0;
    if (state_q == IDLE) begin
      load_vec = in_valid;
    end
    if (state_q == SCAN) begin
      finish_hit  = seg_any;
      finish_zero = !seg_any && last_seg;
      advance     = !seg_any && !last_seg;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= '0;
      seg_idx_q   <= '0;
      output_bits <= '0;
      out_zero    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      if (load_vec) begin
        vec_q     <= input_bits;
        seg_idx_q <= '0;
      end else if (advance) begin
        seg_idx_q <= seg_idx_q + SIW'(1);
      end
      if (finish_hit) begin
        output_bits <= hit_idx;
        out_zero    <= 1'b0;
      end else if (finish_zero) begin
        output_bits <= '0;
        out_zero    <= 1'b1;
      end
    end
  end

`ifdef PRIORITY_ENCODER_SEQ_ONEHOT_CHECK_EN
  logic [IN_BITS-1:0] dec_c;
  assign dec_c = input_bits - IN_BITS'(1);

  // Multi-hot flag captured over the full vector at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_multi <= 1'b0;
    else if (load_vec) out_multi <= |(input_bits & dec_c);
  end
`else
  assign out_multi = 1'b0;
`endif

endmodule

// File: doc/priority_encoder_seq.md
Name: priority_encoder_seq

Overview:
- Multi-cycle encoder: the inverse of the binary-to-one-hot decoder.
- Accepts a 2^OUT_BITS-wide vector and returns the binary index of the lowest set bit.
- Scans SEG_BITS bits per cycle, so very wide vectors (up to 2^20) close timing without a full-width combinational tree.
- Sits between request/grant vectors (one-hot or multi-hot) and index-consuming datapath logic, using valid/ready on both sides.

Parameters:
- OUT_BITS, 8, output index width; input width IN_BITS = 2^OUT_BITS.
- SEG_BITS, 32, bits examined per scan cycle; power of two, 1 <= SEG_BITS <= IN_BITS.
- NUM_SEGS (derived, not overridable), IN_BITS/SEG_BITS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input vector present.
- in_ready  output  1  block can accept a vector.
- input_bits  input  IN_BITS  vector to encode.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- output_bits  output  OUT_BITS  index of the lowest set bit.
- out_zero  output  1  input vector was all zeros.
- out_multi  output  1  more than one bit set (ONEHOT_CHECK_EN only).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - State = IDLE.
  - in_ready = 1, out_valid = 0.
  - output_bits = 0, out_zero = 0, out_multi = 0.
  - Internal vector and segment counter cleared.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch input_bits, seg_idx = 0, go to SCAN.
- SCAN:
  - in_ready = 0; in_valid and input_bits are ignored.
  - Each cycle, examine latched segment seg_idx (bits seg_idx*SEG_BITS +: SEG_BITS).
  - Segment nonzero: output_bits <= seg_idx*SEG_BITS + local lowest-set index, out_zero <= 0, go to DONE (early exit).
  - Segment zero and seg_idx == NUM_SEGS-1: output_bits <= 0, out_zero <= 1, go to DONE.
  - Otherwise: seg_idx <= seg_idx+1.
- DONE:
  - out_valid = 1; output_bits, out_zero and out_multi are held stable until the edge where out_ready = 1.
  - On that edge: out_valid <= 0, go to IDLE.
  - No back-to-back overlap: the next accept occurs at the earliest one edge after the out handshake.
- Latency:
  - Hit in segment j: out_valid rises (j+1) edges after the accepting edge.
  - All-zero vector: NUM_SEGS edges after the accepting edge.
- Arithmetic:
  - seg_idx width is max(1, log2(NUM_SEGS)).
  - Index composition is seg_idx concatenated with the local index, with no adder.
  - SEG_BITS == IN_BITS degenerates to a single scan cycle.
- rst_n asserted in any state: immediate return to reset values; any in-flight vector is discarded with no output.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: PRIORITY_ENCODER_SEQ_ONEHOT_CHECK_EN.
- Defined:
  - At the accepting edge, register out_multi = |(v & (v - 1)) over the full input vector.
  - out_multi is valid alongside output_bits; all-zero input gives out_multi = 0.
- Undefined:
  - out_multi port is still present but tied to 0.
  - No full-width subtract logic is generated.

Decomposition:
- Package encoder_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - a clog2-style width function;
  - derived constants IN_BITS, NUM_SEGS and the seg_idx width function.
- Sub-module seg_priority_encoder:
  - purely combinational;
  - SEG_BITS in, log2(SEG_BITS) lowest-set index out, plus an any-set flag;
  - instanced once, fed by a mux over the latched vector.

Test Plan:
- OUT_BITS=8, SEG_BITS=32, input_bits = 1<<0, out_ready=1 -> output_bits=0, out_zero=0, out_valid 1 edge after accept.
- input_bits = 1<<200 -> output_bits=200 after 7 edges (segment 6); input_bits = 1<<255 -> 255 after 8 edges.
- input_bits = 0 -> out_zero=1, output_bits=0 after 8 edges; in_ready=0 throughout the scan.
- input_bits with bits 37 and 90 set, macro defined -> output_bits=37, out_multi=1; same run with macro undefined -> out_multi=0.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; in_valid pulse during SCAN with a new vector -> ignored, first result unchanged.
- rst_n low for 1 cycle mid-SCAN -> out_valid=0, in_ready=1 immediately; next vector 1<<64 -> output_bits=64 after 3 edges.
